// File: rtl/bg_pkg.sv
// Shared definitions for the background generator: RGB332 colours, flash
// state encoding and default screen geometry.
package bg_pkg;

    // RGB332 colour constants {r[2:0], g[2:0], b[1:0]}
    localparam logic [7:0] BG_BLACK   = 8'h00;
    localparam logic [7:0] BG_YELLOW  = 8'hFC;
    localparam logic [7:0] BG_WHITE   = 8'hFF;
    localparam logic [7:0] BG_RED     = 8'hE0;
    localparam logic [7:0] BG_GREEN   = 8'h10;
    localparam logic [7:0] BG_DKGREEN = 8'h08;

    // Default visible frame size
    localparam int DEF_H_SIZE = 640;
    localparam int DEF_V_SIZE = 480;

    // Pixel coordinate width used by the VGA sync counter
    localparam int PIX_W = 11;

    // Flash animation states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        FLASH_ON  = 2'd2,
        FLASH_OFF = 2'd3
    } flash_state_t;

    // Colour of a field pixel given the selected stripe bit
    function automatic logic [7:0] stripe_color(input logic stripe_bit);
        return stripe_bit ? BG_DKGREEN : BG_GREEN;
    endfunction

endpackage

// File: rtl/bg_flash_fsm.sv
// Frame-synchronous flash animator for the bracket rings. A request arms the
// flash; it starts at the next frame boundary and blinks ON/OFF every
// BLINK_FRAMES frames for FLASH_FRAMES frames. A request while running
// restarts the duration without disturbing the blink phase.
module bg_flash_fsm
    import bg_pkg::*;
#(
    parameter int FLASH_FRAMES = 32,
    parameter int BLINK_FRAMES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic flashReq,
    output logic flashOn,
    output logic flashBusy
);

    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);
    localparam logic [7:0] BLINK_LOAD = 8'(BLINK_FRAMES);

    flash_state_t state_q, state_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]   phase_cnt_q, phase_cnt_d;
    logic         busy_q, busy_d;
    logic [7:0]   frame_dec;
    logic [7:0]   phase_dec;

    // Next-state, counter and busy computation
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        phase_cnt_d = phase_cnt_q;
        frame_dec   = frame_cnt_q - 8'd1;
        phase_dec   = phase_cnt_q - 8'd1;

        case (state_q)
            IDLE: begin
                // A request coinciding with a frame boundary still only arms,
                // so the flash always begins on a clean frame.
                if (flashReq) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (startOfFrame) begin
                    state_d     = FLASH_ON;
                    frame_cnt_d = FLASH_LOAD;
                    phase_cnt_d = BLINK_LOAD;
                end
            end
            FLASH_ON, FLASH_OFF: begin
                if (startOfFrame) begin
                    frame_cnt_d = frame_dec;
                    phase_cnt_d = phase_dec;
                    // End of flash wins over a blink toggle, unless a retrigger
                    // on this very edge extends the flash.
                    if (frame_dec == 8'd0 && !flashReq) begin
                        state_d = IDLE;
                    end else if (phase_dec == 8'd0) begin
                        state_d     = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                        phase_cnt_d = BLINK_LOAD;
                    end
                end
                if (flashReq) begin
                    frame_cnt_d = FLASH_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= 8'd0;
            phase_cnt_q <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign flashOn   = (state_q == FLASH_ON);
    assign flashBusy = busy_q;

endmodule

// File: rtl/back_ground_draw_frames.sv
// Background layer for the VGA path: yellow outer border, NUM_BRACKETS nested
// bracket rings (white, or red while flashing) and a two-tone striped field.
// Output colour is registered: one clock from pixelX/pixelY to BG_RGB.
// Build option: define BG_SCROLL_EN to build the per-frame stripe scroll
// register; without it the stripes are static and scrollEn is ignored.
module back_ground_draw_frames
    import bg_pkg::*;
#(
    parameter int H_SIZE         = DEF_H_SIZE,
    parameter int V_SIZE         = DEF_V_SIZE,
    parameter int BRACKET_OFFSET = 10,
    parameter int NUM_BRACKETS   = 2,
    parameter int STRIPE_LOG2    = 4,
    parameter int FLASH_FRAMES   = 32,
    parameter int BLINK_FRAMES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pixelX,
    input  logic [PIX_W-1:0] pixelY,
    input  logic             startOfFrame,
    input  logic             flashReq,
    input  logic             scrollEn,
    output logic [7:0]       BG_RGB,
    output logic             flashBusy
);

    localparam logic [PIX_W-1:0] H_LIM  = PIX_W'(H_SIZE);
    localparam logic [PIX_W-1:0] V_LIM  = PIX_W'(V_SIZE);
    localparam logic [PIX_W-1:0] H_LAST = PIX_W'(H_SIZE - 1);
    localparam logic [PIX_W-1:0] V_LAST = PIX_W'(V_SIZE - 1);

    logic                   flash_on;
    logic [NUM_BRACKETS-1:0] ring_hit;
    logic [STRIPE_LOG2:0]   scroll_lo;
    logic [STRIPE_LOG2:0]   stripe_sum;
    logic                   stripe_bit;
    logic [7:0]             rgb_q, rgb_d;

    bg_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_flash (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .flashReq     (flashReq),
        .flashOn      (flash_on),
        .flashBusy    (flashBusy)
    );

`ifdef BG_SCROLL_EN
    logic [PIX_W-1:0] scroll_off_q, scroll_off_d;

    // Scroll offset advances once per frame while enabled, wrapping naturally
    always_comb begin
        scroll_off_d = scroll_off_q;
        if (startOfFrame && scrollEn) begin
            scroll_off_d = scroll_off_q + 1'b1;
        end
    end

    // Scroll offset register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_off_q <= '0;
        end else begin
            scroll_off_q <= scroll_off_d;
        end
    end

    assign scroll_lo = scroll_off_q[STRIPE_LOG2:0];
`else
    logic unused_scroll_en;

    assign unused_scroll_en = scrollEn;
    assign scroll_lo        = '0;
`endif

    // One comparator set per ring: left/top at k*offset, right/bottom mirrored
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BRACKETS; gi++) begin : g_ring
            localparam int               RING_OFF = (gi + 1) * BRACKET_OFFSET;
            localparam logic [PIX_W-1:0] RING_LO  = PIX_W'(RING_OFF);
            localparam logic [PIX_W-1:0] RING_HX  = PIX_W'(H_SIZE - 1 - RING_OFF);
            localparam logic [PIX_W-1:0] RING_HY  = PIX_W'(V_SIZE - 1 - RING_OFF);

            assign ring_hit[gi] = (pixelX == RING_LO) || (pixelY == RING_LO) ||
                                  (pixelX == RING_HX) || (pixelY == RING_HY);
        end
    endgenerate

    // Carries only propagate upward, so the stripe bit of the full 12-bit sum
    // equals the top bit of a sum over just the low STRIPE_LOG2+1 bits.
    assign stripe_sum = pixelX[STRIPE_LOG2:0] + pixelY[STRIPE_LOG2:0] + scroll_lo;
    assign stripe_bit = ((stripe_sum >> STRIPE_LOG2) != '0);

    // Priority pixel classifier: off-screen, border, rings, striped field
    always_comb begin
        rgb_d = stripe_color(stripe_bit);
        if (pixelX >= H_LIM || pixelY >= V_LIM) begin
            rgb_d = BG_BLACK;
        end else if (pixelX == '0 || pixelY == '0 ||
                     pixelX == H_LAST || pixelY == V_LAST) begin
            rgb_d = BG_YELLOW;
        end else if (|ring_hit) begin
            rgb_d = flash_on ? BG_RED : BG_WHITE;
        end
    end

    // Output colour register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= BG_WHITE;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign BG_RGB = rgb_q;

endmodule

// File: tb/tb_back_ground_draw_frames.sv
// Self-checking bench for back_ground_draw_frames: constant pixel table,
// hand-written flash/retrigger/reset/scroll sequences and a randomized run,
// all compared against a frame-level behavioural model.
module tb_back_ground_draw_frames;

    localparam int H   = 640;
    localparam int V   = 480;
    localparam int BO  = 10;
    localparam int NB  = 2;
    localparam int SL  = 4;
    localparam int FF  = 32;
    localparam int BF  = 4;
`ifdef BG_SCROLL_EN
    localparam bit SCROLL_BUILT = 1'b1;
`else
    localparam bit SCROLL_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        flashReq = 1'b0;
    logic        scrollEn = 1'b0;
    logic [7:0]  BG_RGB;
    logic        flashBusy;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Behavioural model state (frame-level view of the flash)
    bit m_armed, m_active;
    int m_age, m_left, m_scroll;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[15];

    back_ground_draw_frames #(
        .H_SIZE(H), .V_SIZE(V), .BRACKET_OFFSET(BO), .NUM_BRACKETS(NB),
        .STRIPE_LOG2(SL), .FLASH_FRAMES(FF), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .flashReq(flashReq), .scrollEn(scrollEn),
        .BG_RGB(BG_RGB), .flashBusy(flashBusy)
    );

    always #5 clk = ~clk;

    function automatic bit model_flash_on();
        return m_active && (((m_age / BF) % 2) == 0);
    endfunction

    function automatic logic [7:0] model_color(input int x, input int y);
        int s;
        if (x >= H || y >= V) return 8'h00;
        if (x == 0 || y == 0 || x == H - 1 || y == V - 1) return 8'hFC;
        for (int k = 1; k <= NB; k++) begin
            if (x == k * BO || y == k * BO || x == H - 1 - k * BO || y == V - 1 - k * BO)
                return model_flash_on() ? 8'hE0 : 8'hFF;
        end
        s = (x + y + m_scroll) % 4096;
        return (((s >> SL) & 1) != 0) ? 8'h08 : 8'h10;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_active = 0; m_age = 0; m_left = 0; m_scroll = 0;
    endtask

    task automatic model_update(input bit sof, input bit req, input bit sen);
        if (sof && sen && SCROLL_BUILT) m_scroll = (m_scroll + 1) % 2048;
        if (m_active) begin
            if (sof) begin
                m_age++;
                if (req) m_left = FF;
                else begin
                    m_left--;
                    if (m_left == 0) m_active = 0;
                end
            end else if (req) begin
                m_left = FF;
            end
        end else if (m_armed) begin
            if (sof) begin
                m_armed = 0; m_active = 1; m_age = 0; m_left = FF;
            end
        end else if (req) begin
            m_armed = 1;
        end
    endtask

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end else begin
            $display("ok   %s got=%h", nm, act);
        end
    endtask

    // One clock: drive inputs, predict, clock, compare colour and busy
    task automatic step(input bit sof, input bit req, input bit sen,
                        input int x, input int y, input bit chk);
        logic [7:0] exp_rgb;
        logic       exp_busy;
        startOfFrame = sof; flashReq = req; scrollEn = sen;
        pixelX = 11'(x); pixelY = 11'(y);
        exp_rgb = model_color(x, y);
        @(posedge clk);
        model_update(sof, req, sen);
        exp_busy = m_armed || m_active;
        #1;
        if (chk) begin
            txn++;
            total++;
            if (BG_RGB !== exp_rgb || flashBusy !== exp_busy) begin
                bad++;
                $display("FAIL txn%0d x=%0d y=%0d sof=%0b req=%0b rgb=%h busy=%b want rgb=%h busy=%b",
                         txn, x, y, sof, req, BG_RGB, flashBusy, exp_rgb, exp_busy);
            end else begin
                $display("ok   txn%0d x=%0d y=%0d sof=%0b req=%0b rgb=%h busy=%b",
                         txn, x, y, sof, req, BG_RGB, flashBusy);
            end
        end
    endtask

    task automatic async_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check8("async_reset_rgb", BG_RGB, 8'hFF);
        check8("async_reset_busy", {7'd0, flashBusy}, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int on_frames;
        int rx, ry;

        tbl[0]  = '{0,   5,   8'hFC};
        tbl[1]  = '{10,  100, 8'hFF};
        tbl[2]  = '{20,  100, 8'hFF};
        tbl[3]  = '{629, 200, 8'hFF};
        tbl[4]  = '{30,  100, 8'h10};
        tbl[5]  = '{32,  32,  8'h10};
        tbl[6]  = '{48,  32,  8'h08};
        tbl[7]  = '{700, 100, 8'h00};
        tbl[8]  = '{639, 0,   8'hFC};
        tbl[9]  = '{0,   479, 8'hFC};
        tbl[10] = '{100, 469, 8'hFF};
        tbl[11] = '{100, 459, 8'hFF};
        tbl[12] = '{100, 449, 8'h10};
        tbl[13] = '{640, 479, 8'h00};
        tbl[14] = '{30,  30,  8'h08};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check8("reset_rgb", BG_RGB, 8'hFF);
        check8("reset_busy", {7'd0, flashBusy}, 8'h00);
        reset = 1'b0;

        // Static pixel table
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, tbl[i].x, tbl[i].y, 1);
            check8($sformatf("tbl%0d", i), BG_RGB, tbl[i].exp);
        end

        // 16 frames of scroll, then (32,32) moves to the dark stripe if built
        for (int f = 0; f < 16; f++) begin
            step(1, 0, 1, 0, 0, 0);
            step(0, 0, 1, 0, 0, 0);
        end
        step(0, 0, 0, 32, 32, 1);
        check8("scroll16", BG_RGB, SCROLL_BUILT ? 8'h08 : 8'h10);

        // Flash requested mid-frame: ring stays white until the boundary
        step(0, 1, 0, 10, 100, 1);
        check8("arm_busy", {7'd0, flashBusy}, 8'h01);
        step(0, 0, 0, 10, 100, 1);
        check8("arm_white", BG_RGB, 8'hFF);
        on_frames = 0;
        for (int f = 0; f < 34; f++) begin
            step(1, 0, 0, 10, 100, 1);
            step(0, 0, 0, 10, 100, 1);
            if (BG_RGB == 8'hE0) on_frames++;
            if (f == 0)  check8("flash_first_red", BG_RGB, 8'hE0);
            if (f == 4)  check8("flash_first_off", BG_RGB, 8'hFF);
            if (f == 31) check8("flash_busy31", {7'd0, flashBusy}, 8'h01);
            if (f == 32) check8("flash_idle32", {7'd0, flashBusy}, 8'h00);
        end
        check8("flash_red_frames", 8'(on_frames), 8'd16);

        // Retrigger at frame 30 stretches the flash to frame 62
        step(0, 1, 0, 20, 100, 1);
        for (int f = 0; f < 64; f++) begin
            step(1, 0, 0, 20, 100, 1);
            step(0, (f == 30), 0, 20, 100, 1);
            if (f == 61) check8("retrig_busy61", {7'd0, flashBusy}, 8'h01);
            if (f == 62) check8("retrig_idle62", {7'd0, flashBusy}, 8'h00);
        end

        // Reset at frame 10 of a flash
        step(0, 1, 0, 10, 100, 1);
        for (int f = 0; f < 10; f++) begin
            step(1, 0, 0, 10, 100, 0);
            step(0, 0, 0, 10, 100, 1);
        end
        async_reset();
        step(0, 0, 0, 10, 100, 1);
        check8("post_reset_white", BG_RGB, 8'hFF);

`ifdef BG_SCROLL_EN
        // Scroll wrap 2047 -> 0
        while (m_scroll != 2047) step(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 32, 32, 1);
        check8("wrap_at2047", BG_RGB, 8'h08);
        step(1, 0, 1, 32, 32, 1);
        step(0, 0, 0, 32, 32, 1);
        check8("wrap_at0", BG_RGB, 8'h10);
        step(0, 0, 0, 31, 32, 1);
        check8("wrap_at0_prev", BG_RGB, 8'h08);
`endif

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(1, 0) == 0) begin
                rx = int'($urandom_range(700, 0));
                ry = int'($urandom_range(520, 0));
            end else begin
                rx = 10 * int'($urandom_range(3, 0));
                ry = V - 1 - 10 * int'($urandom_range(3, 0));
                if ($urandom_range(1, 0) == 0) begin
                    rx = H - 1 - rx;
                end
            end
            step(($urandom_range(3, 0) == 0), ($urandom_range(29, 0) == 0),
                 ($urandom_range(1, 0) == 1), rx, ry, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/back_ground_draw_frames.md
# back_ground_draw_frames

Parametrised background generator for the VGA path. Replaces the fixed single-border drawer with:
- a configurable screen size;
- N nested bracket rings;
- a scrolling two-tone striped field;
- a frame-synchronous "flash" animation on the bracket rings, triggered by game logic (level-up, hit).

It sits between the VGA sync counter (pixelX/pixelY, startOfFrame) and the object mux, which uses BG_RGB as the lowest-priority layer.

## Interface
Parameters:
- H_SIZE, 640: visible width in pixels.
- V_SIZE, 480: visible height in pixels.
- BRACKET_OFFSET, 10: spacing between the outer border and each bracket ring, in pixels.
- NUM_BRACKETS, 2: number of bracket rings, 1..8. Ring k (k=1..N) lies at offset k*BRACKET_OFFSET.
- STRIPE_LOG2, 4: stripe width is 2^STRIPE_LOG2 pixels.
- FLASH_FRAMES, 32: flash duration in frames, 1..255.
- BLINK_FRAMES, 4: frames per blink phase, 1..255.

Ports:
- clk, in, 1: pixel clock.
- reset, in, 1: asynchronous, active-high reset.
- pixelX, in, 11: current pixel column.
- pixelY, in, 11: current pixel row.
- startOfFrame, in, 1: single-cycle pulse at the start of each frame.
- flashReq, in, 1: single-cycle flash request.
- scrollEn, in, 1: while high, stripes advance one pixel per frame.
- BG_RGB, out, 8: RGB332 colour {r[2:0], g[2:0], b[1:0]}.
- flashBusy, out, 1: high while a flash is armed or running.

## Operation
Pixel classification. Evaluate in priority order and register the result into BG_RGB:
1. Off-screen (pixelX ≥ H_SIZE or pixelY ≥ V_SIZE): 8'h00.
2. Border (pixelX==0, pixelY==0, pixelX==H_SIZE-1 or pixelY==V_SIZE-1): yellow 8'hFC.
3. Bracket ring k (pixelX or pixelY equals k*BRACKET_OFFSET, or pixelX equals H_SIZE-1-k*BRACKET_OFFSET, or pixelY equals V_SIZE-1-k*BRACKET_OFFSET, for any k in 1..NUM_BRACKETS):
   - white 8'hFF;
   - red 8'hE0 when the flash FSM is in FLASH_ON.
4. Field: s = (pixelX + pixelY + scrollOff), computed in 12 bits.
   - s[STRIPE_LOG2]==0: green 8'h10.
   - otherwise: dark green 8'h08.

Scroll:
- scrollOff is an 11-bit register.
- It increments by 1 on startOfFrame when scrollEn==1.
- It wraps 2047→0.

Flash FSM states: IDLE, ARMED, FLASH_ON, FLASH_OFF.
- IDLE + flashReq → ARMED. The flash is deferred to the frame boundary, so no tearing mid-frame.
- ARMED + startOfFrame → FLASH_ON; frameCnt = FLASH_FRAMES, phaseCnt = BLINK_FRAMES.
- FLASH_ON/FLASH_OFF, on each startOfFrame:
  - frameCnt decrements and phaseCnt decrements.
  - When phaseCnt reaches 0, toggle between ON and OFF and reload phaseCnt.
  - When frameCnt reaches 0, go to IDLE (this takes priority over the toggle).
- flashReq in FLASH_ON/FLASH_OFF: reload frameCnt = FLASH_FRAMES on the same edge; the phase is unchanged (retrigger).
- flashReq and startOfFrame in the same cycle in IDLE: go to ARMED only. The flash starts at the next startOfFrame.
- flashReq in ARMED is ignored.
- flashBusy = (state != IDLE).

## Timing
- Reset values: BG_RGB = 8'hFF, flashBusy = 0, scrollOff = 0, state = IDLE, counters = 0.
- Reset mid-flash returns to IDLE immediately and asynchronously.
- Colour latency: exactly 1 clk from pixelX/pixelY to BG_RGB. The sync counter must delay its blanking by 1 cycle to match.
- Frame-level changes take effect from the first pixel after the startOfFrame edge:
  - the flash state (FLASH_ON colour);
  - scrollOff.
- flashBusy is registered and rises 1 cycle after flashReq.
- A flash of FLASH_FRAMES=32 with BLINK_FRAMES=4 gives 4 ON/OFF pairs, then returns to IDLE.

## Configuration
- BG_SCROLL_EN defined: the scrollOff register is built and scrollEn is honoured.
- BG_SCROLL_EN undefined: scrollOff is the constant 0, scrollEn is ignored, and the stripes are static.
- Ports are identical in both builds.

## Structure
- Package bg_pkg holds:
  - colour constants BG_BLACK, BG_YELLOW, BG_WHITE, BG_RED, BG_GREEN, BG_DKGREEN;
  - the flash state enum flash_state_t;
  - the default frame-size constants.
- One sub-module, bg_flash_fsm. It owns the state register, frameCnt and phaseCnt. Its inputs are startOfFrame and flashReq; its outputs are flashOn and flashBusy.
- The pixel classifier and the scroll register stay in the top module.

## Test plan
- Reset → BG_RGB=8'hFF, flashBusy=0. Release reset, drive pixel (0,5) → BG_RGB=8'hFC one clk later.
- Defaults, pixels (10,100), (20,100), (629,200), (30,100):
  - expect 8'hFF, 8'hFF, 8'hFF;
  - then a field colour for (30,100), since it is not on a ring.
- Field with scrollOff=0: (32,32) → s=64, bit4=0 → 8'h10; (48,32) → s=80, bit4=1 → 8'h08. After 16 frames with scrollEn=1, (32,32) → 8'h08.
- flashReq mid-frame:
  - flashBusy=1; ring pixel (10,100) stays 8'hFF until the next startOfFrame;
  - then 8'hE0 for 4 frames, 8'hFF for 4 frames, repeating;
  - IDLE after 32 frames.
- Retrigger: flashReq at frame 30 of a running flash → the flash lasts until frame 62. Reset asserted at frame 10 → immediately IDLE, flashBusy=0.
- Off-screen pixel (700,100) → 8'h00. scrollOff at 2047 plus one frame → 0, and the stripe is continuous with that at offset 2047 mod 2^(STRIPE_LOG2+1).
